shift_seq: RTL and testbench
============================

# shift_seq

Parametrised, registered successor to the 4-bit combinational shifter. It holds a WIDTH-bit word and performs a multi-cycle shift or rotate of a requested amount, one bit position per clock. The operation uses a start/busy/done handshake. It sits as a datapath register in the state-machine lab designs, where a controller loads a word, issues a shift command, and waits for completion.

## Interface
- WIDTH, 8, data word width (≥2)
- CNTW, 4, width of the shift-amount field; maximum amount is 2^CNTW−1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  synchronous parallel load of din (IDLE only)
- din  input  WIDTH  parallel load data
- start  input  1  begin a shift operation (IDLE only)
- mode  input  3  operation select, sampled at start
- amount  input  CNTW  number of 1-bit steps, sampled at start
- ser_in  input  1  fill bit for logical shifts, sampled every step
- dout  output  WIDTH  register contents
- busy  output  1  high while the state is not IDLE
- done  output  1  one-cycle completion pulse

## Operation
- Mode encoding:
  - 000: hold
  - 001: shift left; LSB ← ser_in
  - 010: shift right logical; MSB ← ser_in
  - 011: rotate left
  - 100: rotate right
  - 101: arithmetic shift right; MSB replicated
  - 110, 111: treated as hold; the step count still runs
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - load=1: dout ← din on this edge. start is ignored on the same edge, so load has priority.
  - load=0 and start=1: latch mode and amount into internal registers; remaining ← amount. Go to SHIFT if amount≠0, else go to DONE.
  - Neither asserted: hold.
- SHIFT:
  - Each edge applies one step of the latched mode to dout and decrements remaining.
  - When remaining==1 before the decrement, go to DONE.
- DONE: done=1 for exactly this cycle; the next edge returns to IDLE.
- While busy, load, start, mode and amount are ignored. A start held high stays ignored until IDLE. A start still high in the first IDLE cycle begins a new operation.
- An amount larger than WIDTH is legal:
  - Shifts saturate naturally to all-fill.
  - Rotates wrap modulo WIDTH.
- Async reset (rst_n=0), including mid-operation:
  - dout=0, busy=0, done=0
  - state=IDLE, remaining=0, latched mode=000
  - Operation resumes on the first clock edge after rst_n rises.

## Timing
- Take the start edge as edge 0.
- For amount=N≥1:
  - Steps are applied on edges 1..N.
  - busy is high from edge 0 through edge N+1 (SHIFT for N cycles, then DONE).
  - done is high between edge N and edge N+1.
  - The final dout is valid in the same cycle done is high.
- For amount=0: done is high between edge 0 and edge 1, busy is high that single cycle, and dout is unchanged.
- Back-to-back: the minimum spacing between start edges is N+2 cycles.
- A load takes effect on the next edge, with zero latency to dout after that edge.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset with rst_n=0 mid-SHIFT (after 0x5A loaded, ROL 5 running) → dout=0x00, busy=0, done=0 immediately without a clock. After release, IDLE accepts a new load.
- Shift left, WIDTH=8: load 0xB4, start mode=001, amount=3, ser_in=0 → busy 4 cycles, done pulse on the 4th, dout=0xA0. Shift right logical with ser_in=1, amount=1 on 0x00 → 0x80.
- Rotate: load 0xB4, mode=100, amount=4 → 0x4B. Load 0x5A, mode=011, amount=8 → 0x5A after 8 steps. mode=011, amount=9 on 0x5A → 0xB4 (wrap).
- Arithmetic shift right: load 0x84, mode=101, amount=2 → 0xE1. Amount 15 on 0x84 → 0xFF. mode=001, amount=15, ser_in=0 on 0xFF → 0x00.
- Edge cases:
  - amount=0 → done on the next cycle, dout unchanged.
  - load and start on the same edge → load wins, no operation starts.
  - mode=110, amount=3 → busy 4 cycles, dout unchanged.
- Ignored during busy: during SHIFT, assert load with din=0xFF, start, and change mode/amount → none take effect, and the result matches the originally latched command. A start held high through done begins a second operation in the first IDLE cycle.

Source files
------------

// File: rtl/shift_seq_if.sv
// shift_seq_if: command/data bundle between a lab controller and the
// shift_seq datapath register.
//   load, din            parallel load request and data
//   start, mode, amount  shift command, sampled when start is accepted
//   ser_in               fill bit for logical shifts, sampled every step
//   dout                 register contents
//   busy, done           operation in progress / one-cycle completion pulse
// master: the controller side.  slave: the shift_seq side.
interface shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [2:0]       mode;
  logic [CNTW-1:0]  amount;
  logic             ser_in;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output load, din, start, mode, amount, ser_in,
    input  dout, busy, done
  );

  modport slave (
    input  load, din, start, mode, amount, ser_in,
    output dout, busy, done
  );
endinterface

// File: rtl/shift_seq.sv
// shift_seq: WIDTH-bit register that performs a multi-cycle shift/rotate,
// one bit position per clock, under a start/busy/done handshake.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_seq_if.slave (load/din, start/mode/amount, ser_in,
//          dout, busy, done)
// Mode: 000 hold, 001 shl (lsb<-ser_in), 010 shr (msb<-ser_in),
//       011 rol, 100 ror, 101 asr, 110/111 hold (step count still runs).
//
// state    | meaning
// ST_IDLE  | accepts load (priority) or start
// ST_SHIFT | one step of the latched mode per clock, counting down
// ST_DONE  | done pulse, returns to ST_IDLE on the next edge
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input logic        clk,
  input logic        rst_n,
  shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] step_val;
  logic [2:0]       mode_q;
  logic [CNTW-1:0]  rem_q;
  logic             busy_d;
  logic             done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.load && bus.start) begin
          state_d = (bus.amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_q == CNTW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  assign bus.busy = busy_d;
  assign bus.done = done_d;
  assign bus.dout = dout_q;

  // One step of the latched operation applied to the current word
  always_comb begin
    step_val = dout_q;
    case (mode_q)
      3'b001:  step_val = {dout_q[WIDTH-2:0], bus.ser_in};
      3'b010:  step_val = {bus.ser_in, dout_q[WIDTH-1:1]};
      3'b011:  step_val = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
      3'b100:  step_val = {dout_q[0], dout_q[WIDTH-1:1]};
      3'b101:  step_val = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
      default: step_val = dout_q;
    endcase
  end

  // Datapath: word, latched command, remaining step count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      mode_q <= 3'b000;
      rem_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load) begin
            dout_q <= bus.din;
          end else if (bus.start) begin
            mode_q <= bus.mode;
            rem_q  <= bus.amount;
          end
        end
        ST_SHIFT: begin
          dout_q <= step_val;
          rem_q  <= rem_q - CNTW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  typedef struct {
    logic [7:0] d;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  int   busy_cnt;
  exp_t q[$];

  shift_seq_if #(.WIDTH(8), .CNTW(4)) bus ();

  shift_seq #(.WIDTH(8), .CNTW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: counts busy cycles and checks each done against the queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        n_vec++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_done: dout=%02h with no operation expected", bus.dout);
        end else begin
          e = q.pop_front();
          if (bus.dout !== e.d || busy_cnt != e.lat) begin
            n_fail++;
            $display("FAIL op_result: dout=%02h busy_cycles=%0d, expected dout=%02h busy_cycles=%0d",
                     bus.dout, busy_cnt, e.d, e.lat);
          end
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load = 1'b1;
    bus.din  = v;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check("load", bus.dout, v);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus.busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: busy still %b after %0d cycles, expected 0", bus.busy, k);
    end
  endtask

  task automatic do_op(input logic [2:0] m, input int amt, input logic s, input logic [7:0] exp);
    exp_t e;
    e.d   = exp;
    e.lat = amt + 1;
    q.push_back(e);
    bus.mode   = m;
    bus.amount = 4'(amt);
    bus.ser_in = s;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
  endtask

  initial begin
    exp_t e;
    n_vec = 0;
    n_fail = 0;
    busy_cnt = 0;
    rst_n      = 1'b0;
    bus.load   = 1'b0;
    bus.din    = '0;
    bus.start  = 1'b0;
    bus.mode   = 3'b000;
    bus.amount = '0;
    bus.ser_in = 1'b0;
    #12;
    check("reset_dout", bus.dout, 8'h00);
    check("reset_busy", {7'b0, bus.busy}, 8'h00);
    check("reset_done", {7'b0, bus.done}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_load(8'hB4);
    do_op(3'b001, 3, 1'b0, 8'hA0);
    do_load(8'h00);
    do_op(3'b010, 1, 1'b1, 8'h80);
    do_load(8'hB4);
    do_op(3'b100, 4, 1'b0, 8'h4B);
    do_load(8'h5A);
    do_op(3'b011, 8, 1'b0, 8'h5A);
    do_load(8'h5A);
    do_op(3'b011, 9, 1'b0, 8'hB4);
    do_load(8'h84);
    do_op(3'b101, 2, 1'b0, 8'hE1);
    do_load(8'h84);
    do_op(3'b101, 15, 1'b0, 8'hFF);
    do_load(8'hFF);
    do_op(3'b001, 15, 1'b0, 8'h00);
    do_load(8'h3C);
    do_op(3'b001, 0, 1'b0, 8'h3C);
    do_load(8'h69);
    do_op(3'b110, 3, 1'b1, 8'h69);

    // load and start on the same edge: load wins
    bus.load   = 1'b1;
    bus.din    = 8'hC3;
    bus.start  = 1'b1;
    bus.mode   = 3'b001;
    bus.amount = 4'd2;
    @(posedge clk); #1;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    check("load_prio_dout", bus.dout, 8'hC3);
    check("load_prio_busy", {7'b0, bus.busy}, 8'h00);
    @(posedge clk); #1;
    check("load_prio_after", bus.dout, 8'hC3);

    // inputs ignored while busy; held start reissues in first IDLE cycle
    do_load(8'hB4);
    e.d = 8'hA0; e.lat = 4; q.push_back(e);
    e.d = 8'h28; e.lat = 3; q.push_back(e);
    bus.mode   = 3'b001;
    bus.amount = 4'd3;
    bus.ser_in = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.load   = 1'b1;
    bus.din    = 8'hFF;
    bus.mode   = 3'b011;
    bus.amount = 4'd7;
    @(posedge clk); #1;
    bus.load   = 1'b0;
    bus.mode   = 3'b010;
    bus.amount = 4'd2;
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("reissue_busy", {7'b0, bus.busy}, 8'h01);
    wait_idle();

    // asynchronous reset in the middle of a rotate
    do_load(8'h5A);
    bus.mode   = 3'b011;
    bus.amount = 4'd5;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", bus.dout, 8'h00);
    check("async_rst_busy", {7'b0, bus.busy}, 8'h00);
    check("async_rst_done", {7'b0, bus.done}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_load(8'h77);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_hold", bus.dout, 8'h77);
    check("queue_drained", 8'(q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
